// File: rtl/riscv_sim_harness_ctrl_pkg.sv
// Shared encodings and constants for the RISC-V run controller.
package riscv_sim_harness_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOOP    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_0FF0;
  localparam int unsigned PASS_VAL        = 1;

  // Any terminal state; the run has finished one way or another.
  function automatic logic is_done(input state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_LOOP) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/riscv_sim_harness_ctrl_if.sv
// Core-side retire and store bus observed by the run controller.
interface riscv_sim_harness_ctrl_if #(
  parameter int XLEN = 32
) ();
  logic            retire_valid;
  logic [XLEN-1:0] retire_pc;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;

  // The core drives the bus; the controller only watches it.
  modport master (output retire_valid, retire_pc, dmem_we, dmem_addr, dmem_wdata);
  modport slave  (input  retire_valid, retire_pc, dmem_we, dmem_addr, dmem_wdata);
endinterface

// File: rtl/riscv_sim_harness_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module riscv_sim_harness_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  // Count up on inc, stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr_i)               cnt_q <= '0;
    else if (inc_i && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/riscv_sim_harness_ctrl.sv
// Run controller: holds the core in reset, runs it, and decides how the test ended.
module riscv_sim_harness_ctrl
  import riscv_sim_harness_ctrl_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              RST_CYCLES  = 2,
  parameter int              MAX_CYCLES  = 1000,
  parameter int              CNT_W       = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEF),
  parameter int              LOOP_N      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  riscv_sim_harness_ctrl_if.slave  bus,
  output logic                     core_reset,
  output logic                     running,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [XLEN-1:0]          fail_code,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         retire_count
);
  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam int RW = $clog2(LOOP_N + 1);

  state_e          state_q, state_d;
  logic [HW-1:0]   hold_q;
  logic [XLEN-1:0] last_pc_q;
  logic [RW-1:0]   rpt_q;
  logic            pass_q, fail_q, timeout_q;
  logic [XLEN-1:0] fail_code_q;

  logic run, in_hold, tohost_hit, tohost_pass, same_pc, loop_hit, budget_hit;

  assign run         = (state_q == ST_RUN);
  assign in_hold     = (state_q == ST_HOLD);
  assign tohost_hit  = run && bus.dmem_we && (bus.dmem_addr == TOHOST_ADDR);
  assign tohost_pass = (bus.dmem_wdata == XLEN'(PASS_VAL));
  // rpt_q == 0 means nothing has retired yet, so last_pc_q is not meaningful.
  assign same_pc     = (rpt_q != '0) && (bus.retire_pc == last_pc_q);
  assign loop_hit    = run && bus.retire_valid && same_pc && (rpt_q == RW'(LOOP_N - 1));
  // This RUN cycle is the last one in the budget.
  assign budget_hit  = run && (cycle_count >= CNT_W'(MAX_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_HOLD;
    else       state_q <= state_d;
  end

  // Next-state: tohost beats self-loop beats timeout; done states are terminal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: if (hold_q == HW'(RST_CYCLES - 1)) state_d = ST_RUN;
      ST_RUN: begin
        if (tohost_hit)      state_d = tohost_pass ? ST_PASS : ST_FAIL;
        else if (loop_hit)   state_d = ST_LOOP;
        else if (budget_hit) state_d = ST_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  // Decoded outputs straight from the state register.
  always_comb begin
    core_reset = !run;
    running    = run;
    done       = is_done(state_q);
  end

  // Hold counter times the core reset pulse.
  always_ff @(posedge clk) begin
    if (reset)        hold_q <= '0;
    else if (in_hold) hold_q <= hold_q + 1'b1;
  end

  // Track the last retired PC and how many times in a row it retired.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_pc_q <= '0;
      rpt_q     <= '0;
    end else if (run && bus.retire_valid) begin
      last_pc_q <= bus.retire_pc;
      rpt_q     <= same_pc ? rpt_q + 1'b1 : RW'(1);
    end
  end

  // Result flags latch on the RUN exit edge and then stay put.
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
    end else if (run) begin
      pass_q      <= (state_d == ST_PASS);
      fail_q      <= (state_d == ST_FAIL);
      timeout_q   <= (state_d == ST_TIMEOUT);
      fail_code_q <= (state_d == ST_FAIL) ? (bus.dmem_wdata >> 1) : '0;
    end
  end

  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign fail_code = fail_code_q;

  riscv_sim_harness_ctrl_sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr_i (in_hold),
    .inc_i (run),
    .cnt_o (cycle_count)
  );

  riscv_sim_harness_ctrl_sat_counter #(.W(CNT_W)) u_ret_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr_i (in_hold),
    .inc_i (run && bus.retire_valid),
    .cnt_o (retire_count)
  );
endmodule

// File: tb/tb_riscv_sim_harness_ctrl.sv
// Scoreboard bench for the run controller: each test queues its expected end result,
// a monitor checks it when done rises.
module tb_riscv_sim_harness_ctrl;
  localparam int XLEN = 32;
  localparam int CNT_W = 32;

  typedef struct {
    logic            pass;
    logic            fail;
    logic            timeout;
    logic [XLEN-1:0] code;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] ret;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic core_reset, running, done, pass, fail, timeout;
  logic [XLEN-1:0]  fail_code;
  logic [CNT_W-1:0] cycle_count, retire_count;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];
  logic done_prev = 1'b0;

  riscv_sim_harness_ctrl_if #(.XLEN(XLEN)) bus ();

  riscv_sim_harness_ctrl #(
    .XLEN(XLEN), .RST_CYCLES(3), .MAX_CYCLES(20), .CNT_W(CNT_W),
    .TOHOST_ADDR(32'h0000_0FF0), .LOOP_N(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .core_reset(core_reset), .running(running), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout), .fail_code(fail_code),
    .cycle_count(cycle_count), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: on each rising done, pop the expected result and compare.
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 want no pending result");
      end else begin
        e = sb_q.pop_front();
        chk("end_pass",    64'(pass),         64'(e.pass));
        chk("end_fail",    64'(fail),         64'(e.fail));
        chk("end_timeout", 64'(timeout),      64'(e.timeout));
        chk("end_code",    64'(fail_code),    64'(e.code));
        chk("end_cycles",  64'(cycle_count),  64'(e.cyc));
        chk("end_retires", 64'(retire_count), 64'(e.ret));
        chk("end_corerst", 64'(core_reset),   64'd1);
      end
    end
    done_prev = done;
  end

  task automatic clr_in();
    bus.retire_valid = 1'b0; bus.retire_pc = '0;
    bus.dmem_we = 1'b0; bus.dmem_addr = '0; bus.dmem_wdata = '0;
  endtask

  // One cycle of bus activity, presented at a negedge and removed at the next.
  task automatic ev(input logic we, input logic [31:0] a, input logic [31:0] d,
                    input logic rv, input logic [31:0] pc);
    bus.dmem_we = we; bus.dmem_addr = a; bus.dmem_wdata = d;
    bus.retire_valid = rv; bus.retire_pc = pc;
    @(negedge clk);
    clr_in();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic p, input logic f, input logic t,
                      input logic [31:0] code, input int cyc, input int ret);
    exp_t e;
    e.pass = p; e.fail = f; e.timeout = t; e.code = code;
    e.cyc = CNT_W'(cyc); e.ret = CNT_W'(ret);
    sb_q.push_back(e);
  endtask

  // Reset, check cleared state and the 3-cycle hold; returns at negedge of RUN cycle 1.
  task automatic release_rst(input bit hold_store);
    reset = 1'b1; clr_in();
    @(negedge clk);
    chk("rst_core_reset", 64'(core_reset),   64'd1);
    chk("rst_running",    64'(running),      64'd0);
    chk("rst_done",       64'(done),         64'd0);
    chk("rst_flags",      64'({pass, fail, timeout}), 64'd0);
    chk("rst_code",       64'(fail_code),    64'd0);
    chk("rst_cycles",     64'(cycle_count),  64'd0);
    chk("rst_retires",    64'(retire_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    if (hold_store) begin
      bus.dmem_we = 1'b1; bus.dmem_addr = 32'h0FF0; bus.dmem_wdata = 32'd1;
    end
    for (int i = 0; i < 3; i++) begin
      chk("hold_core_reset", 64'(core_reset), 64'd1);
      chk("hold_running",    64'(running),    64'd0);
      if (i < 2) @(negedge clk);
    end
    clr_in();
    @(negedge clk);
    chk("run_running",    64'(running),     64'd1);
    chk("run_core_reset", 64'(core_reset),  64'd0);
    chk("run_done",       64'(done),        64'd0);
    chk("run_cycles0",    64'(cycle_count), 64'd0);
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL wait_done: got done=0 want done=1 within %0d cycles", max);
    end
    idle(1);
  endtask

  initial begin
    clr_in();
    @(negedge clk);

    // Pass at RUN cycle 10; later activity must not disturb the result.
    release_rst(1'b0);
    push(1, 0, 0, 0, 10, 0);
    idle(9);
    ev(1'b1, 32'h0FF0, 32'd1, 1'b0, 32'h0);
    wait_done(5);
    ev(1'b1, 32'h0FF0, 32'd7, 1'b1, 32'h10);
    idle(2);
    chk("frozen_cycles",  64'(cycle_count),  64'd10);
    chk("frozen_retires", 64'(retire_count), 64'd0);
    chk("frozen_pass",    64'(pass),         64'd1);
    chk("frozen_fail",    64'(fail),         64'd0);
    chk("frozen_corerst", 64'(core_reset),   64'd1);

    // Store during HOLD is ignored; store to 0xFF4 ignored; store 7 -> fail, code 3.
    release_rst(1'b1);
    push(0, 1, 0, 32'd3, 5, 0);
    ev(1'b1, 32'h0FF4, 32'd5, 1'b0, 32'h0);
    chk("ff4_running", 64'(running), 64'd1);
    idle(3);
    ev(1'b1, 32'h0FF0, 32'd7, 1'b0, 32'h0);
    wait_done(5);

    // Four retires at 0x40 with idle gaps -> LOOP.
    release_rst(1'b0);
    push(0, 0, 0, 0, 9, 4);
    ev(1'b0, 0, 0, 1'b1, 32'h40);
    idle(2);
    ev(1'b0, 0, 0, 1'b1, 32'h40);
    idle(1);
    ev(1'b0, 0, 0, 1'b1, 32'h40);
    idle(2);
    ev(1'b0, 0, 0, 1'b1, 32'h40);
    wait_done(5);

    // Repeat broken by 0x44 -> keeps running, ends by timeout after 20 cycles.
    release_rst(1'b0);
    push(0, 0, 1, 0, 20, 7);
    for (int i = 0; i < 3; i++) ev(1'b0, 0, 0, 1'b1, 32'h40);
    ev(1'b0, 0, 0, 1'b1, 32'h44);
    for (int i = 0; i < 3; i++) ev(1'b0, 0, 0, 1'b1, 32'h40);
    chk("noloop_running", 64'(running), 64'd1);
    wait_done(30);

    // Pure timeout.
    release_rst(1'b0);
    push(0, 0, 1, 0, 20, 0);
    wait_done(30);

    // tohost, loop and timeout all in cycle 20 -> pass.
    release_rst(1'b0);
    push(1, 0, 0, 0, 20, 4);
    idle(16);
    for (int i = 0; i < 3; i++) ev(1'b0, 0, 0, 1'b1, 32'h80);
    ev(1'b1, 32'h0FF0, 32'd1, 1'b1, 32'h80);
    wait_done(5);

    // Loop and timeout in cycle 20 -> loop.
    release_rst(1'b0);
    push(0, 0, 0, 0, 20, 4);
    idle(16);
    for (int i = 0; i < 4; i++) ev(1'b0, 0, 0, 1'b1, 32'h90);
    wait_done(5);

    // Reset mid-RUN at cycle 5, then a fresh run passes at cycle 3.
    release_rst(1'b0);
    ev(1'b0, 0, 0, 1'b1, 32'h20);
    idle(3);
    release_rst(1'b0);
    push(1, 0, 0, 0, 3, 0);
    idle(2);
    ev(1'b1, 32'h0FF0, 32'd1, 1'b0, 32'h0);
    wait_done(5);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
